apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 42 ++++
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB requester/completer signals for apb_master.
// The master modport is the bridge's view; the slave modport is the other side.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, pwdata, psel, penable, pwrite,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, pwdata, psel, penable, pwrite,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns one accepted command into a SETUP/ACCESS
// transfer and reports completion, slave error or wait-state timeout.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         pclk,
    input  logic         presetn,
    apb_master_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic timeout_hit;

    assign bus.cmd_ready = presetn && (state_q == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    // cnt_q counts wait cycles already spent; this cycle would be wait number cnt_q+1
    assign timeout_hit   = (TIMEOUT > 0) && ((int'(cnt_q) + 1) >= TIMEOUT);

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    cnt_d         = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a driver issues commands, a negedge slave/monitor
// plays the APB completer and scores every transfer and response against its own plan.
module tb_apb_master;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        tmo;
        int          nacc;
    } rsp_t;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    int          plan_w[$];
    logic        plan_err[$];
    logic [31:0] plan_rd[$];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- completer model + scoreboard ----------------
    cmd_t        mc;
    rsp_t        er;
    int          cur_w = 0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_rd = '0;
    int          acc_k = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;
    logic        last_tmo = 1'b0;
    int          setup_prev = 0;
    int          setup_last = 0;

    initial begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
    end

    always @(negedge pclk) begin
        if (!presetn) begin
            rsp_q.delete();
            cmd_q.delete();
            acc_k    = 0;
            last_rd  = '0;
            last_err = 1'b0;
            last_tmo = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, er.rd);
                    chk("rsp_err", bus.rsp_err, er.err);
                    chk("rsp_timeout", bus.rsp_timeout, er.tmo);
                    chk("access_cycles", acc_k, er.nacc);
                    chk("psel_at_rsp", bus.psel, 0);
                    last_rd  = er.rd;
                    last_err = er.err;
                    last_tmo = er.tmo;
                end
            end else begin
                chk("rsp_hold_rdata", bus.rsp_rdata, last_rd);
                chk("rsp_hold_flags", {bus.rsp_err, bus.rsp_timeout}, {last_err, last_tmo});
            end

            if (bus.psel && !bus.penable) begin
                if (cmd_q.size() == 0) begin
                    chk("setup_without_cmd", {63'd0, bus.psel}, 64'd0);
                end else begin
                    mc = cmd_q.pop_front();
                    chk("setup_paddr", bus.paddr, mc.a);
                    chk("setup_pwrite", bus.pwrite, mc.w);
                    chk("setup_pwdata", bus.pwdata, mc.w ? mc.d : 32'd0);
                    if (plan_w.size() != 0) begin
                        cur_w   = plan_w.pop_front();
                        cur_err = plan_err.pop_front();
                        cur_rd  = plan_rd.pop_front();
                    end else begin
                        cur_w   = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
                        cur_err = ($urandom_range(0, 3) == 0);
                        cur_rd  = $urandom;
                    end
                    // pready in access cycle index cur_w; too late means the bridge gives up
                    if (cur_w < TIMEOUT)
                        rsp_q.push_back('{mc.w ? 32'd0 : cur_rd, cur_err, 1'b0, cur_w + 1});
                    else
                        rsp_q.push_back('{32'd0, 1'b1, 1'b1, TIMEOUT});
                    acc_k      = 0;
                    setup_prev = setup_last;
                    setup_last = cyc;
                end
                bus.pready  = $urandom_range(0, 1) == 1;
                bus.pslverr = $urandom_range(0, 1) == 1;
                bus.prdata  = $urandom;
            end else if (bus.psel && bus.penable) begin
                chk("access_paddr", bus.paddr, mc.a);
                chk("access_pwrite", bus.pwrite, mc.w);
                chk("access_pwdata", bus.pwdata, mc.w ? mc.d : 32'd0);
                bus.pready  = (acc_k == cur_w);
                bus.pslverr = (acc_k == cur_w) ? cur_err : ($urandom_range(0, 1) == 1);
                bus.prdata  = (acc_k == cur_w) ? cur_rd : $urandom;
                acc_k++;
            end else begin
                chk("penable_without_psel", bus.penable, 0);
                bus.pready  = $urandom_range(0, 1) == 1;
                bus.pslverr = $urandom_range(0, 1) == 1;
                bus.prdata  = $urandom;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic plan(input int w, input logic e, input logic [31:0] rd);
        plan_w.push_back(w);
        plan_err.push_back(e);
        plan_rd.push_back(rd);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic got = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int t = 0; t < 100; t++) begin
            got = bus.cmd_ready;
            @(posedge pclk); #1;
            if (got) begin
                cmd_q.push_back('{w, a, d});
                return;
            end
        end
        chk("cmd_accept", got, 1);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.cmd_write = $urandom_range(0, 1) == 1;
            bus.cmd_addr  = $urandom;
            bus.cmd_wdata = $urandom;
            @(posedge pclk); #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.cmd_valid = 1'b0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0) && t < 200) begin
            @(posedge pclk); #1;
            t++;
        end
        chk("drain", t < 200, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        repeat (2) @(posedge pclk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_psel_penable", {bus.psel, bus.penable, bus.pwrite}, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        presetn = 1'b1;
        #1;
        chk("cmd_ready_after_rst", bus.cmd_ready, 1);
        @(posedge pclk); #1;

        // zero-wait write, one-wait read, slave error, timeout
        plan(0, 1'b0, 32'h1234_5678);
        issue(1'b1, 32'h4, 32'h0000_0017);
        drain();
        plan(1, 1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 32'h10, 32'h5555_AAAA);
        drain();
        plan(0, 1'b1, 32'h0BAD_F00D);
        issue(1'b0, 32'h40, 32'h0);
        drain();
        plan(50, 1'b0, 32'hFFFF_FFFF);
        issue(1'b0, 32'h80, 32'h0);
        drain();
        plan(3, 1'b0, 32'hCAFE_0003);
        issue(1'b0, 32'h84, 32'h0);
        drain();

        // back-to-back with cmd_valid held high
        plan(0, 1'b0, 32'h0);
        plan(0, 1'b0, 32'h0);
        issue(1'b1, 32'h0, 32'hA5A5_0000);
        issue(1'b1, 32'h8, 32'hA5A5_0008);
        drain();
        chk("b2b_spacing", setup_last - setup_prev, 3);

        // reset during an ACCESS wait state
        plan(50, 1'b0, 32'h0);
        issue(1'b0, 32'h100, 32'h0);
        bus.cmd_valid = 1'b0;
        t = 0;
        while (!(bus.psel && bus.penable) && t < 20) begin
            @(posedge pclk); #1;
            t++;
        end
        chk("reach_access", t < 20, 1);
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        chk("cmd_ready_in_rst", bus.cmd_ready, 0);
        @(posedge pclk); #1;
        chk("midrst_psel_penable", {bus.psel, bus.penable}, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        @(posedge pclk); #1;
        chk("midrst_rsp_valid2", bus.rsp_valid, 0);
        presetn = 1'b1;
        #1;
        chk("cmd_ready_after_midrst", bus.cmd_ready, 1);
        @(posedge pclk); #1;
        chk("no_rsp_after_midrst", bus.rsp_valid, 0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            issue($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
